// File: rtl/wireshark_nios2e_cpu_ocimem_pkg.sv
// Shared constants and types for the Nios II/e on-chip instrumentation memory controller.
// Holds the jdo field positions, the register-space offset and the controller state enum.
package wireshark_nios2e_cpu_ocimem_pkg;

    localparam int ADDR_W_DEF   = 8;
    localparam int DATA_W_DEF   = 32;
    localparam int JDO_W        = 38;

    localparam int JDO_ADDR_LSB = 10;
    localparam int JDO_ADDR_MSB = 17;
    localparam int JDO_DATA_LSB = 3;
    localparam int JDO_DATA_MSB = 34;
    localparam int JDO_SET_GO   = 23;
    localparam int JDO_CLR_ERR  = 24;
    localparam int JDO_CLR_RDY  = 25;
    localparam int JDO_RD       = 26;

    localparam int REG_OFFSET   = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        JRD  = 2'd1,
        JWR  = 2'd2,
        CRD  = 2'd3
    } state_t;

endpackage

// File: rtl/wireshark_nios2e_cpu_ocimem_ram.sv
// Single-port debug RAM with byte-lane write enables and a registered (1-cycle) read.
// A write and a read of the same word in one cycle returns the old contents.
module wireshark_nios2e_cpu_ocimem_ram #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic [ADDR_W-1:0]   addr,
    input  logic                we,
    input  logic [DATA_W/8-1:0] be,
    input  logic [DATA_W-1:0]   wdata,
    output logic [DATA_W-1:0]   rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // NOTE: the array has no reset so it maps onto block RAM; contents are undefined until written.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < DATA_W/8; i++) begin
                if (be[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/wireshark_nios2e_cpu_ocimem_ctrl.sv
// Debug RAM controller: arbitrates the 256x32 instrumentation RAM between JTAG strobes and the
// CPU debug slave port, and owns the monitor handshake flags.
module wireshark_nios2e_cpu_ocimem_ctrl
    import wireshark_nios2e_cpu_ocimem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [JDO_W-1:0]    jdo,
    input  logic                take_action_ocimem_a,
    input  logic                take_action_ocimem_b,
    input  logic                take_no_action_ocimem_a,
    input  logic [ADDR_W:0]     address,
    input  logic                chipselect,
    input  logic                read,
    input  logic                write,
    input  logic                debugaccess,
    input  logic [DATA_W-1:0]   writedata,
    input  logic [DATA_W/8-1:0] byteenable,
    output logic [DATA_W-1:0]   readdata,
    output logic                waitrequest,
    output logic [DATA_W-1:0]   MonDReg,
    output logic                monitor_ready,
    output logic                monitor_error,
    output logic                monitor_go
);

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   mon_areg;
    logic [DATA_W-1:0]   wr_data;
    logic                pend_rd, pend_wr;
    logic                crd_reg_q, crd_off_q;

    logic                jrd_req, jwr_req, serve_rd, serve_wr, areg_inc;
    logic                cpu_rd, cpu_wr, cpu_wr_done, cpu_reg_wr;
    logic                reg_sel, reg_off_ok;
    logic [DATA_W-1:0]   reg_value;

    logic                ram_we;
    logic [ADDR_W-1:0]   ram_addr;
    logic [DATA_W/8-1:0] ram_be;
    logic [DATA_W-1:0]   ram_wdata, ram_rdata;
    logic                jdo_unused;

    assign jdo_unused = ^{jdo[JDO_W-1:JDO_DATA_MSB+1], jdo[JDO_DATA_LSB-1:0]};

    // A live strobe counts as a request in the same cycle, so IDLE serves it without a latch delay.
    assign jrd_req    = pend_rd | take_no_action_ocimem_a;
    assign jwr_req    = pend_wr | take_action_ocimem_b;
    assign cpu_rd     = chipselect & read;
    assign cpu_wr     = chipselect & write & ~read;
    assign reg_sel    = address[ADDR_W];
    assign reg_off_ok = (address[ADDR_W-1:0] == ADDR_W'(REG_OFFSET));
    assign cpu_reg_wr = cpu_wr_done & reg_sel & reg_off_ok & debugaccess;
    assign reg_value  = {{(DATA_W-3){1'b0}}, monitor_go, monitor_error, monitor_ready};

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt   = state;
        serve_rd    = 1'b0;
        serve_wr    = 1'b0;
        areg_inc    = 1'b0;
        cpu_wr_done = 1'b0;
        ram_we      = 1'b0;
        ram_addr    = mon_areg;
        ram_be      = '1;
        ram_wdata   = wr_data;
        readdata    = '0;
        waitrequest = chipselect & (read | write);

        unique case (state)
            IDLE: begin
                if (jwr_req) begin
                    serve_wr  = 1'b1;
                    state_nxt = JWR;
                end else if (jrd_req) begin
                    serve_rd  = 1'b1;
                    areg_inc  = 1'b1;
                    state_nxt = JRD;
                end else if (cpu_rd) begin
                    ram_addr  = address[ADDR_W-1:0];
                    state_nxt = CRD;
                end else if (cpu_wr) begin
                    ram_addr    = address[ADDR_W-1:0];
                    ram_be      = byteenable;
                    ram_wdata   = writedata;
                    ram_we      = ~reset & debugaccess & ~reg_sel;
                    cpu_wr_done = 1'b1;
                    waitrequest = 1'b0;
                end
            end
            JRD: state_nxt = IDLE;
            JWR: begin
                // Gated by reset so an abandoned JTAG write never reaches the RAM.
                ram_we    = ~reset;
                areg_inc  = 1'b1;
                state_nxt = IDLE;
            end
            CRD: begin
                readdata    = crd_reg_q ? (crd_off_q ? reg_value : '0) : ram_rdata;
                waitrequest = 1'b0;
                state_nxt   = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            mon_areg      <= '0;
            wr_data       <= '0;
            pend_rd       <= 1'b0;
            pend_wr       <= 1'b0;
            crd_reg_q     <= 1'b0;
            crd_off_q     <= 1'b0;
            MonDReg       <= '0;
            monitor_ready <= 1'b0;
            monitor_error <= 1'b0;
            monitor_go    <= 1'b0;
        end else begin
            state   <= state_nxt;
            pend_wr <= (pend_wr | take_action_ocimem_b) & ~serve_wr;
            // An address-load read must wait a cycle for the new pointer, so it is always latched.
            pend_rd <= ((pend_rd | take_no_action_ocimem_a) & ~serve_rd)
                     | (take_action_ocimem_a & jdo[JDO_RD]);

            if (take_action_ocimem_b) wr_data <= DATA_W'(jdo[JDO_DATA_MSB:JDO_DATA_LSB]);

            if (take_action_ocimem_a) mon_areg <= jdo[JDO_ADDR_MSB:JDO_ADDR_LSB];
            else if (areg_inc)        mon_areg <= mon_areg + 1'b1;

            if (state == JRD) MonDReg <= ram_rdata;

            if (state == IDLE) begin
                crd_reg_q <= reg_sel;
                crd_off_q <= reg_off_ok;
            end

            if (cpu_reg_wr && writedata[0])                   monitor_ready <= 1'b1;
            else if (take_action_ocimem_a && jdo[JDO_CLR_RDY]) monitor_ready <= 1'b0;

            if (cpu_reg_wr && writedata[1])                   monitor_error <= 1'b1;
            else if (take_action_ocimem_a && jdo[JDO_CLR_ERR]) monitor_error <= 1'b0;

            if (take_action_ocimem_a && jdo[JDO_SET_GO]) monitor_go <= 1'b1;
            else if (cpu_reg_wr && writedata[0])        monitor_go <= 1'b0;
        end
    end

    wireshark_nios2e_cpu_ocimem_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk   (clk),
        .addr  (ram_addr),
        .we    (ram_we),
        .be    (ram_be),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_wireshark_nios2e_cpu_ocimem_ctrl.sv
// Self-checking bench for the OCI memory controller: transaction-level reference model,
// table-driven CPU byte-lane vectors, directed timing/corner sequences and random traffic.
module tb_wireshark_nios2e_cpu_ocimem_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [37:0] jdo;
    logic        take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a;
    logic [8:0]  address;
    logic        chipselect, read, write, debugaccess;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] readdata;
    logic        waitrequest;
    logic [31:0] MonDReg;
    logic        monitor_ready, monitor_error, monitor_go;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: whole-word memory image, pointer, read-back register and flags.
    logic [31:0] m_mem [256];
    logic [7:0]  m_areg;
    logic [31:0] m_mon;
    logic        m_rdy, m_err, m_go;

    always #5 clk = ~clk;

    wireshark_nios2e_cpu_ocimem_ctrl dut (
        .clk                     (clk),
        .reset                   (reset),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .address                 (address),
        .chipselect              (chipselect),
        .read                    (read),
        .write                   (write),
        .debugaccess             (debugaccess),
        .writedata               (writedata),
        .byteenable              (byteenable),
        .readdata                (readdata),
        .waitrequest             (waitrequest),
        .MonDReg                 (MonDReg),
        .monitor_ready           (monitor_ready),
        .monitor_error           (monitor_error),
        .monitor_go              (monitor_go)
    );

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] init;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        dbg;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        jdo = '0;
        take_action_ocimem_a = 1'b0;
        take_action_ocimem_b = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        address = '0;
        chipselect = 1'b0;
        read = 1'b0;
        write = 1'b0;
        debugaccess = 1'b0;
        writedata = '0;
        byteenable = '0;
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = wd[b*8 +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_regval();
        return {29'b0, m_go, m_err, m_rdy};
    endfunction

    task automatic model_reset();
        m_areg = '0;
        m_mon  = '0;
        m_rdy  = 1'b0;
        m_err  = 1'b0;
        m_go   = 1'b0;
    endtask

    task automatic check_jtag(input string tag);
        check({tag, "_mondreg"}, MonDReg, m_mon);
        check({tag, "_flags"}, {29'b0, monitor_go, monitor_error, monitor_ready}, m_regval());
    endtask

    task automatic jtag_load(input logic [7:0] a, input logic rd, input logic crdy,
                             input logic cerr, input logic sgo);
        jdo = '0;
        jdo[17:10] = a;
        jdo[26] = rd;
        jdo[25] = crdy;
        jdo[24] = cerr;
        jdo[23] = sgo;
        take_action_ocimem_a = 1'b1;
        step();
        take_action_ocimem_a = 1'b0;
        jdo = '0;
        repeat (4) step();
        m_areg = a;
        if (crdy) m_rdy = 1'b0;
        if (cerr) m_err = 1'b0;
        if (sgo)  m_go  = 1'b1;
        if (rd) begin
            m_mon  = m_mem[m_areg];
            m_areg = m_areg + 8'd1;
        end
    endtask

    task automatic jtag_write(input logic [31:0] d);
        jdo = '0;
        jdo[34:3] = d;
        take_action_ocimem_b = 1'b1;
        step();
        take_action_ocimem_b = 1'b0;
        jdo = '0;
        repeat (3) step();
        m_mem[m_areg] = d;
        m_areg = m_areg + 8'd1;
    endtask

    task automatic jtag_read();
        take_no_action_ocimem_a = 1'b1;
        step();
        take_no_action_ocimem_a = 1'b0;
        repeat (3) step();
        m_mon  = m_mem[m_areg];
        m_areg = m_areg + 8'd1;
    endtask

    task automatic cpu_read(input logic [8:0] a, output logic [31:0] data, output int waits);
        bit done = 0;
        chipselect = 1'b1;
        read = 1'b1;
        address = a;
        waits = 0;
        data = '0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (!waitrequest) begin
                data = readdata;
                done = 1;
            end else begin
                waits++;
            end
            step();
        end
        chipselect = 1'b0;
        read = 1'b0;
        check("cpu_rd_completes", {31'b0, done}, 32'd1);
        step();
    endtask

    task automatic cpu_write(input logic [8:0] a, input logic [31:0] d, input logic [3:0] be,
                             input logic dbg, output int waits);
        bit done = 0;
        chipselect = 1'b1;
        write = 1'b1;
        address = a;
        writedata = d;
        byteenable = be;
        debugaccess = dbg;
        waits = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (!waitrequest) done = 1;
            else waits++;
            step();
        end
        clear_inputs();
        check("cpu_wr_completes", {31'b0, done}, 32'd1);
        step();
        if (a[8]) begin
            if (dbg && a[7:0] == 8'd0) begin
                if (d[0]) begin
                    m_rdy = 1'b1;
                    m_go  = 1'b0;
                end
                if (d[1]) m_err = 1'b1;
            end
        end else if (dbg) begin
            m_mem[a[7:0]] = merge(m_mem[a[7:0]], d, be);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] rdata;
        int          waits;
        bit          done;

        vecs[0] = '{8'd5,   32'h0000_0000, 32'hAABB_CCDD, 4'b0101, 1'b1, 32'h00BB_00DD};
        vecs[1] = '{8'd5,   32'h00BB_00DD, 32'hAABB_CCDD, 4'b0101, 1'b0, 32'h00BB_00DD};
        vecs[2] = '{8'd9,   32'h1111_1111, 32'hAABB_CCDD, 4'b1010, 1'b1, 32'hAA11_CC11};
        vecs[3] = '{8'd12,  32'h0000_0000, 32'h1234_5678, 4'b1111, 1'b1, 32'h1234_5678};
        vecs[4] = '{8'd200, 32'h5555_5555, 32'hFFFF_FFFF, 4'b0000, 1'b1, 32'h5555_5555};
        vecs[5] = '{8'd255, 32'h0F0F_0F0F, 32'h0000_0000, 4'b1000, 1'b1, 32'h000F_0F0F};

        clear_inputs();
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        check("reset_readdata", readdata, 32'h0);
        check("reset_waitrequest", {31'b0, waitrequest}, 32'h0);
        check_jtag("reset");
        step();

        // Fill the whole RAM through JTAG so the model knows every word; pointer wraps back to 0.
        jtag_load(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 256; i++) jtag_write(32'h5A00_0000 ^ (i * 32'h0001_0203));
        jtag_read();
        check_jtag("fill_wrap");

        // JTAG write/read-back with strobe-to-MonDReg latency.
        jtag_load(8'h10, 1'b0, 1'b0, 1'b0, 1'b0);
        jtag_write(32'hDEAD_BEEF);
        jtag_load(8'h10, 1'b0, 1'b0, 1'b0, 1'b0);
        take_no_action_ocimem_a = 1'b1;
        step();
        take_no_action_ocimem_a = 1'b0;
        @(negedge clk);
        check("jrd_latency_1", MonDReg, m_mon);
        step();
        @(negedge clk);
        check("jrd_latency_2", MonDReg, 32'hDEAD_BEEF);
        repeat (2) step();
        m_mon = 32'hDEAD_BEEF;
        m_areg = 8'h11;
        jtag_write(32'hCAFE_0012);
        jtag_load(8'h11, 1'b1, 1'b0, 1'b0, 1'b0);
        check_jtag("jrd_pointer");
        jtag_load(8'h10, 1'b1, 1'b0, 1'b0, 1'b0);
        check_jtag("jload_rd");

        // Pointer wrap on consecutive JTAG writes.
        jtag_load(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
        jtag_write(32'h1);
        jtag_write(32'h2);
        jtag_load(8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
        check("wrap_ff", MonDReg, 32'h1);
        jtag_read();
        check("wrap_00", MonDReg, 32'h2);

        // Table-driven CPU byte-lane writes followed by a 2-cycle read.
        for (int v = 0; v < 6; v++) begin
            jtag_load(vecs[v].addr, 1'b0, 1'b0, 1'b0, 1'b0);
            jtag_write(vecs[v].init);
            cpu_write({1'b0, vecs[v].addr}, vecs[v].wdata, vecs[v].be, vecs[v].dbg, waits);
            check($sformatf("vec%0d_wr_waits", v), waits, 0);
            cpu_read({1'b0, vecs[v].addr}, rdata, waits);
            check($sformatf("vec%0d_rd_data", v), rdata, vecs[v].exp);
            check($sformatf("vec%0d_rd_waits", v), waits, 1);
        end

        // JTAG read and CPU read in the same cycle: JTAG first, CPU stalled three cycles.
        jtag_load(8'h30, 1'b0, 1'b0, 1'b0, 1'b0);
        jtag_write(32'h0BAD_F00D);
        jtag_load(8'h30, 1'b0, 1'b0, 1'b0, 1'b0);
        take_no_action_ocimem_a = 1'b1;
        chipselect = 1'b1;
        read = 1'b1;
        address = 9'd5;
        waits = 0;
        done = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (!waitrequest) begin
                rdata = readdata;
                done = 1;
            end else begin
                waits++;
            end
            step();
            take_no_action_ocimem_a = 1'b0;
        end
        clear_inputs();
        step();
        check("contend_done", {31'b0, done}, 32'd1);
        check("contend_waits", waits, 3);
        check("contend_cpu_data", rdata, m_mem[5]);
        m_mon = 32'h0BAD_F00D;
        m_areg = 8'h31;
        check_jtag("contend_jtag");

        // CPU write colliding with a JTAG write strobe waits until JTAG work drains.
        jtag_load(8'h40, 1'b0, 1'b0, 1'b0, 1'b0);
        jdo[34:3] = 32'h1111_0000;
        take_action_ocimem_b = 1'b1;
        chipselect = 1'b1;
        write = 1'b1;
        address = 9'd6;
        writedata = 32'h0000_0066;
        byteenable = 4'hF;
        debugaccess = 1'b1;
        waits = 0;
        done = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (!waitrequest) done = 1;
            else waits++;
            step();
            take_action_ocimem_b = 1'b0;
        end
        clear_inputs();
        step();
        check("wr_contend_waits", waits, 2);
        m_mem[8'h40] = 32'h1111_0000;
        m_mem[6] = 32'h0000_0066;
        m_areg = 8'h41;
        cpu_read(9'd6, rdata, waits);
        check("wr_contend_cpu", rdata, 32'h0000_0066);
        jtag_load(8'h40, 1'b1, 1'b0, 1'b0, 1'b0);
        check_jtag("wr_contend_jtag");

        // Monitor flag handshake.
        jtag_load(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        check("flag_go_set", {31'b0, monitor_go}, 32'd1);
        cpu_write(9'h100, 32'h1, 4'hF, 1'b1, waits);
        check("flag_ready_set", {30'b0, monitor_go, monitor_ready}, 32'h1);
        cpu_read(9'h100, rdata, waits);
        check("flag_reg_read", rdata, 32'h1);
        check("flag_reg_waits", waits, 1);
        cpu_write(9'h100, 32'h2, 4'hF, 1'b0, waits);
        check_jtag("flag_no_dbg");
        cpu_write(9'h100, 32'h2, 4'hF, 1'b1, waits);
        check("flag_err_set", {31'b0, monitor_error}, 32'd1);
        jtag_load(8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
        check_jtag("flag_jtag_clear");

        // Same-cycle conflict: CPU set beats JTAG clear, JTAG go-set beats CPU go-clear.
        jdo = '0;
        jdo[25] = 1'b1;
        jdo[24] = 1'b1;
        jdo[23] = 1'b1;
        take_action_ocimem_a = 1'b1;
        chipselect = 1'b1;
        write = 1'b1;
        address = 9'h100;
        writedata = 32'h3;
        debugaccess = 1'b1;
        @(negedge clk);
        check("conflict_zero_wait", {31'b0, waitrequest}, 32'h0);
        step();
        clear_inputs();
        @(negedge clk);
        check("conflict_flags", {29'b0, monitor_go, monitor_error, monitor_ready}, 32'h7);
        step();
        m_rdy = 1'b1;
        m_err = 1'b1;
        m_go = 1'b1;
        m_areg = 8'h00;

        // Reset while a JTAG write is in flight must not touch the RAM.
        jtag_load(8'h20, 1'b0, 1'b0, 1'b0, 1'b0);
        jtag_write(32'h1234_5678);
        jtag_load(8'h20, 1'b0, 1'b0, 1'b0, 1'b0);
        jdo[34:3] = 32'hBAD0_BAD0;
        take_action_ocimem_b = 1'b1;
        step();
        clear_inputs();
        reset = 1'b1;
        step();
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        check_jtag("rst_jwr");
        step();
        jtag_load(8'h20, 1'b1, 1'b0, 1'b0, 1'b0);
        check("rst_jwr_ram", MonDReg, 32'h1234_5678);

        // Reset during a CPU read with a JTAG write arriving.
        jtag_load(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        chipselect = 1'b1;
        read = 1'b1;
        address = 9'd5;
        step();
        jdo[34:3] = 32'hBAD1_BAD1;
        take_action_ocimem_b = 1'b1;
        reset = 1'b1;
        step();
        clear_inputs();
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        check("rst_crd_readdata", readdata, 32'h0);
        check("rst_crd_waitreq", {31'b0, waitrequest}, 32'h0);
        check_jtag("rst_crd");
        repeat (3) step();
        jtag_load(8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        check_jtag("rst_crd_ram");

        // Random transaction traffic against the model.
        for (int n = 0; n < 150; n++) begin
            logic [31:0] r = $urandom;
            case ($urandom_range(0, 5))
                0: jtag_load(r[7:0], r[8], r[9] & r[10], r[11] & r[12], r[13]);
                1: jtag_write($urandom);
                2: jtag_read();
                3: begin
                    cpu_read({1'b0, r[7:0]}, rdata, waits);
                    check("rnd_cpu_rd", rdata, m_mem[r[7:0]]);
                    check("rnd_cpu_rd_waits", waits, 1);
                end
                4: begin
                    cpu_write({1'b0, r[7:0]}, $urandom, r[11:8], r[12] | r[13], waits);
                    check("rnd_cpu_wr_waits", waits, 0);
                end
                default: begin
                    if (r[8]) begin
                        cpu_read({1'b1, 6'b0, r[1:0] & {2{r[2]}}}, rdata, waits);
                        check("rnd_reg_rd", rdata,
                              (r[1:0] & {2{r[2]}}) == 2'd0 ? m_regval() : 32'h0);
                    end else begin
                        cpu_write({1'b1, 7'b0, r[3] & r[4]}, {30'b0, r[6:5]}, 4'hF, r[7], waits);
                    end
                end
            endcase
            check_jtag("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
